// File: rtl/uart_msg_seq.sv
`default_nettype none
// ============================================================================
// Module      : uart_msg_seq
// Description : Wishbone master that initialises a uart_top (LCR/DLAB, divisor,
//               line control) and then sends the packed MSG parameter, polling
//               LSR.THRE before every THR write.
//               Optional macro UART_MSG_SEQ_REPEAT_EN: resend the message forever
//               after a 2^16-cycle gap, without re-initialising the UART.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_msg_seq #(
    parameter logic [15:0]  DIVISOR     = 16'd3,
    parameter logic [7:0]   LCR_VAL     = 8'h1B,
    parameter int           MSG_LEN     = 4,
    parameter logic [511:0] MSG         = 512'h5A657573,
    parameter bit           AUTO_START  = 1'b1,
    parameter int           ACK_TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    output logic [4:0]  wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  state_o
);

    localparam logic [5:0] c_LAST_IDX = 6'(MSG_LEN - 1);
    localparam logic [7:0] c_TMO_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LCR_D = 4'd1,
        S_DL1   = 4'd2,
        S_DL2   = 4'd3,
        S_LCR   = 4'd4,
        S_POLL  = 4'd5,
        S_THR   = 4'd6,
        S_DONE  = 4'd7,
`ifdef UART_MSG_SEQ_REPEAT_EN
        S_ERR   = 4'd8,
        S_GAP   = 4'd9
`else
        S_ERR   = 4'd8
`endif
    } state_t;

    state_t      r_state;
    logic        r_auto;
    logic [5:0]  r_idx;
    logic [7:0]  r_tmo;
    logic [4:0]  r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic        r_we;
    logic        r_stb;
    logic        r_cyc;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
`ifdef UART_MSG_SEQ_REPEAT_EN
    logic [15:0] r_gap;
`endif

    logic [4:0]  w_adr;
    logic [7:0]  w_val;
    logic        w_we;
    logic [31:0] w_dat;
    logic [3:0]  w_sel;
    logic [5:0]  w_rev;
    logic [7:0]  w_msg_byte;
    logic        w_thre;
    logic        w_unused_dat;

    // Byte 0 is the most significant of the MSG_LEN bytes packed into MSG.
    assign w_rev        = c_LAST_IDX - r_idx;
    assign w_msg_byte   = 8'(MSG >> {w_rev, 3'b000});
    assign w_thre       = wbm_dat_i[13];
    assign w_unused_dat = ^{wbm_dat_i[31:14], wbm_dat_i[12:0]};

    always_comb begin
        w_adr = 5'd0;
        w_val = 8'h00;
        w_we  = 1'b0;
        case (r_state)
            S_LCR_D: begin w_adr = 5'd3; w_val = LCR_VAL | 8'h80; w_we = 1'b1; end
            S_DL1:   begin w_adr = 5'd0; w_val = DIVISOR[7:0];    w_we = 1'b1; end
            S_DL2:   begin w_adr = 5'd1; w_val = DIVISOR[15:8];   w_we = 1'b1; end
            S_LCR:   begin w_adr = 5'd3; w_val = LCR_VAL;         w_we = 1'b1; end
            S_POLL:  begin w_adr = 5'd5; end
            S_THR:   begin w_adr = 5'd0; w_val = w_msg_byte;      w_we = 1'b1; end
            default: ;
        endcase
    end

    assign w_dat = {24'h0, w_val} << {w_adr[1:0], 3'b000};
    assign w_sel = 4'b0001 << w_adr[1:0];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_auto  <= AUTO_START;
            r_idx   <= 6'd0;
            r_tmo   <= 8'd0;
            r_adr   <= 5'd0;
            r_dat   <= 32'd0;
            r_sel   <= 4'd0;
            r_we    <= 1'b0;
            r_stb   <= 1'b0;
            r_cyc   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef UART_MSG_SEQ_REPEAT_EN
            r_gap   <= 16'd0;
`endif
        end else begin
            r_auto <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i || (r_auto && r_state == S_IDLE)) begin
                        r_state <= S_LCR_D;
                        r_idx   <= 6'd0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
`ifdef UART_MSG_SEQ_REPEAT_EN
                S_GAP: begin
                    r_done <= 1'b0;
                    r_gap  <= r_gap + 16'd1;
                    if (r_gap == 16'hFFFF) begin
                        r_idx   <= 6'd0;
                        r_state <= S_POLL;
                    end
                end
`endif
                default: begin
                    // The cycle after an ack leaves stb low, giving the idle gap.
                    if (!r_stb) begin
                        r_adr <= w_adr;
                        r_dat <= w_dat;
                        r_sel <= w_sel;
                        r_we  <= w_we;
                        r_cyc <= 1'b1;
                        r_stb <= 1'b1;
                        r_tmo <= 8'd0;
                    end else if (wbm_ack_i) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_we  <= 1'b0;
                        case (r_state)
                            S_LCR_D: r_state <= S_DL1;
                            S_DL1:   r_state <= S_DL2;
                            S_DL2:   r_state <= S_LCR;
                            S_LCR:   r_state <= S_POLL;
                            S_POLL:  if (w_thre) r_state <= S_THR;
                            S_THR: begin
                                if (r_idx == c_LAST_IDX) begin
                                    r_done <= 1'b1;
`ifdef UART_MSG_SEQ_REPEAT_EN
                                    r_gap   <= 16'd0;
                                    r_state <= S_GAP;
`else
                                    r_busy  <= 1'b0;
                                    r_state <= S_DONE;
`endif
                                end else begin
                                    r_idx   <= r_idx + 6'd1;
                                    r_state <= S_POLL;
                                end
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
            endcase
        end
    end

    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign wbm_sel_o = r_sel;
    assign wbm_we_o  = r_we;
    assign wbm_stb_o = r_stb;
    assign wbm_cyc_o = r_cyc;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign state_o   = {4'h0, r_state};

endmodule
`default_nettype wire

// File: tb/tb_uart_msg_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_msg_seq
// Description : Scoreboard bench for uart_msg_seq; three instances (defaults,
//               manual start, custom divisor with a one-byte message).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_msg_seq;

    typedef struct packed {
        logic [4:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        we;
    } xact_t;

    logic        clk = 1'b0;
    logic        rst  [3];
    logic        start[3];
    logic [4:0]  adr  [3];
    logic [31:0] dato [3];
    logic [31:0] dati [3];
    logic [3:0]  sel  [3];
    logic        we   [3];
    logic        stb  [3];
    logic        cyc  [3];
    logic        ack  [3];
    logic        busy [3];
    logic        done [3];
    logic        err  [3];
    logic [7:0]  st   [3];
    logic        ack_en[3];
    int          rd_cnt[3];
    int          zero_until[3];

    xact_t q0[$];
    xact_t q1[$];
    xact_t q2[$];

    int checks = 0;
    int errors = 0;

    logic [7:0] msg_a [4] = '{8'h5A, 8'h65, 8'h75, 8'h73};

    always #5 clk = ~clk;

    uart_msg_seq u_a (
        .wb_clk_i(clk), .wb_rst_i(rst[0]), .start_i(start[0]),
        .wbm_adr_o(adr[0]), .wbm_dat_o(dato[0]), .wbm_dat_i(dati[0]),
        .wbm_sel_o(sel[0]), .wbm_we_o(we[0]), .wbm_stb_o(stb[0]),
        .wbm_cyc_o(cyc[0]), .wbm_ack_i(ack[0]), .busy_o(busy[0]),
        .done_o(done[0]), .err_o(err[0]), .state_o(st[0])
    );

    uart_msg_seq #(.AUTO_START(1'b0)) u_b (
        .wb_clk_i(clk), .wb_rst_i(rst[1]), .start_i(start[1]),
        .wbm_adr_o(adr[1]), .wbm_dat_o(dato[1]), .wbm_dat_i(dati[1]),
        .wbm_sel_o(sel[1]), .wbm_we_o(we[1]), .wbm_stb_o(stb[1]),
        .wbm_cyc_o(cyc[1]), .wbm_ack_i(ack[1]), .busy_o(busy[1]),
        .done_o(done[1]), .err_o(err[1]), .state_o(st[1])
    );

    uart_msg_seq #(.AUTO_START(1'b0), .DIVISOR(16'h0145), .MSG_LEN(1), .MSG(512'h41)) u_c (
        .wb_clk_i(clk), .wb_rst_i(rst[2]), .start_i(start[2]),
        .wbm_adr_o(adr[2]), .wbm_dat_o(dato[2]), .wbm_dat_i(dati[2]),
        .wbm_sel_o(sel[2]), .wbm_we_o(we[2]), .wbm_stb_o(stb[2]),
        .wbm_cyc_o(cyc[2]), .wbm_ack_i(ack[2]), .busy_o(busy[2]),
        .done_o(done[2]), .err_o(err[2]), .state_o(st[2])
    );

    // Slave model: ack one cycle after stb; LS reads report THRE=0 until rd_cnt reaches zero_until.
    always_comb begin
        for (int k = 0; k < 3; k++)
            dati[k] = (rd_cnt[k] < zero_until[k]) ? 32'h0000_0000 : 32'h0000_6000;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                ack[k] <= 1'b0;
            end else begin
                ack[k] <= stb[k] && !ack[k] && ack_en[k];
                if (stb[k] && ack[k] && !we[k]) rd_cnt[k] <= rd_cnt[k] + 1;
            end
        end
    end

    function automatic void push(int k, logic [4:0] a, logic [3:0] s, logic [31:0] d, logic w);
        xact_t x;
        x = '{adr: a, sel: s, dat: d, we: w};
        case (k)
            0: q0.push_back(x);
            1: q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endfunction

    function automatic void push_init(int k, logic [15:0] div, logic [7:0] lcr);
        push(k, 5'd3, 4'b1000, {lcr | 8'h80, 24'h0}, 1'b1);
        push(k, 5'd0, 4'b0001, {24'h0, div[7:0]}, 1'b1);
        push(k, 5'd1, 4'b0010, {16'h0, div[15:8], 8'h0}, 1'b1);
        push(k, 5'd3, 4'b1000, {lcr, 24'h0}, 1'b1);
    endfunction

    function automatic void push_byte(int k, logic [7:0] b, int nreads);
        for (int r = 0; r < nreads; r++) push(k, 5'd5, 4'b0010, 32'h0, 1'b0);
        push(k, 5'd0, 4'b0001, {24'h0, b}, 1'b1);
    endfunction

    function automatic int qsize(int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void check_xact(int k);
        xact_t got, exp;
        got = '{adr: adr[k], sel: sel[k], dat: dato[k], we: we[k]};
        checks++;
        if (qsize(k) == 0) begin
            errors++;
            $display("FAIL xact dut%0d unexpected adr=%h sel=%b dat=%h we=%b", k, got.adr, got.sel, got.dat, got.we);
            return;
        end
        case (k)
            0: exp = q0.pop_front();
            1: exp = q1.pop_front();
            default: exp = q2.pop_front();
        endcase
        if (got !== exp) begin
            errors++;
            $display("FAIL xact dut%0d got adr=%h sel=%b dat=%h we=%b expected adr=%h sel=%b dat=%h we=%b",
                     k, got.adr, got.sel, got.dat, got.we, exp.adr, exp.sel, exp.dat, exp.we);
        end
    endfunction

    // Monitor: every acknowledged access is matched against the scoreboard.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++)
            if (!rst[k] && stb[k] && ack[k]) check_xact(k);
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic pulse_start(int k);
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_done(int k, int budget);
        int n = 0;
        while (!done[k] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("done_timeout_dut%0d", k), {31'd0, done[k]}, 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; start[k] = 1'b0; ack_en[k] = 1'b1;
            rd_cnt[k] = 0; zero_until[k] = 0;
        end
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cyc", {31'd0, cyc[0]}, 32'd0);
        chk("rst_stb", {31'd0, stb[0]}, 32'd0);
        chk("rst_flags", {29'd0, busy[0], done[0], err[0]}, 32'd0);
        chk("rst_state", {24'd0, st[0]}, 32'd0);
        chk("rst_bus", {sel[0], adr[0], we[0]} , 32'd0);
        chk("rst_dat", dato[0], 32'd0);

        // Auto-start run with default parameters
        push_init(0, 16'd3, 8'h1B);
        for (int i = 0; i < 4; i++) push_byte(0, msg_a[i], 1);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        wait_done(0, 500);
        chk("a1_busy", {31'd0, busy[0]}, 32'd0);
        chk("a1_state", {24'd0, st[0]}, 32'd7);
        chk("a1_queue", qsize(0), 32'd0);
        chk("b_no_autostart", {31'd0, cyc[1]}, 32'd0);
        chk("b_idle_state", {24'd0, st[1]}, 32'd0);

        // THRE low three times before the first byte
        push_init(0, 16'd3, 8'h1B);
        push_byte(0, msg_a[0], 4);
        for (int i = 1; i < 4; i++) push_byte(0, msg_a[i], 1);
        zero_until[0] = rd_cnt[0] + 3;
        pulse_start(0);
        chk("a2_done_clr", {31'd0, done[0]}, 32'd0);
        chk("a2_busy", {31'd0, busy[0]}, 32'd1);
        wait_done(0, 800);
        chk("a2_queue", qsize(0), 32'd0);

        // Ack timeout on the first access
        ack_en[0] = 1'b0;
        pulse_start(0);
        begin
            int n = 0;
            int hi = 0;
            while (!stb[0] && n < 20) begin @(negedge clk); n++; end
            while (stb[0] && hi < 400) begin @(negedge clk); hi++; end
            chk("tmo_stb_cycles", hi, 32'd255);
        end
        chk("tmo_err", {31'd0, err[0]}, 32'd1);
        chk("tmo_state", {24'd0, st[0]}, 32'd8);
        chk("tmo_busy", {31'd0, busy[0]}, 32'd0);
        ack_en[0] = 1'b1;
        push_init(0, 16'd3, 8'h1B);
        for (int i = 0; i < 4; i++) push_byte(0, msg_a[i], 1);
        pulse_start(0);
        chk("restart_err_clr", {31'd0, err[0]}, 32'd0);
        wait_done(0, 500);
        chk("restart_queue", qsize(0), 32'd0);

        // Manual start, ignored re-start, reset during the third byte
        push_init(1, 16'd3, 8'h1B);
        push_byte(1, msg_a[0], 1);
        push_byte(1, msg_a[1], 1);
        push(1, 5'd5, 4'b0010, 32'h0, 1'b0);
        pulse_start(1);
        repeat (6) @(negedge clk);
        pulse_start(1);
        begin
            int n = 0;
            while (!(stb[1] && we[1] && dato[1] == 32'h75) && n < 300) begin @(negedge clk); n++; end
            chk("b_third_byte_seen", {31'd0, stb[1]}, 32'd1);
        end
        rst[1] = 1'b1;
        #1;
        chk("b_async_cyc", {31'd0, cyc[1]}, 32'd0);
        chk("b_async_stb", {31'd0, stb[1]}, 32'd0);
        chk("b_async_busy", {31'd0, busy[1]}, 32'd0);
        chk("b_queue_at_rst", qsize(1), 32'd0);
        repeat (3) @(negedge clk);
        rst[1] = 1'b0;
        begin
            int act = 0;
            for (int i = 0; i < 30; i++) begin @(negedge clk); if (cyc[1]) act++; end
            chk("b_quiet_after_rst", act, 32'd0);
        end
        push_init(1, 16'd3, 8'h1B);
        for (int i = 0; i < 4; i++) push_byte(1, msg_a[i], 1);
        pulse_start(1);
        wait_done(1, 500);
        chk("b_queue", qsize(1), 32'd0);

        // Custom divisor, single-byte message
        push_init(2, 16'h0145, 8'h1B);
        push_byte(2, 8'h41, 1);
        pulse_start(2);
        wait_done(2, 300);
        chk("c_busy", {31'd0, busy[2]}, 32'd0);
        chk("c_state", {24'd0, st[2]}, 32'd7);
        chk("c_queue", qsize(2), 32'd0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
